free_list: RTL

FREE_LIST -- requirements
Module: free_list

---
 rtl/free_list_pkg.sv | 17 +
 rtl/free_list_picker.sv | 28 ++
 rtl/free_list.sv | 116 +++++++++++
 3 files changed

// File: rtl/free_list_pkg.sv
// Shared sizing defaults for the physical-register free list.
// The system-wide macros normally come from sys_defs.svh; the guarded fallbacks keep this slice self-contained.
`ifndef N
`define N 3
`endif
`ifndef PHYS_REG_SZ_R10K
`define PHYS_REG_SZ_R10K 64
`endif
`ifndef ARCH_REG_SZ
`define ARCH_REG_SZ 32
`endif

package free_list_pkg;
    localparam int DEF_N          = `N;
    localparam int DEF_PHYS_REGS  = `PHYS_REG_SZ_R10K;
    localparam int DEF_ARCH_COUNT = `ARCH_REG_SZ;
endpackage

// File: rtl/free_list_picker.sv
// Selects the 1st..LANES-th lowest set bits of a bitmap as one-hot vectors.
// Each lane strips the previous lane's pick, so the picks are always distinct.
module nth_free_picker #(
    parameter int WIDTH = 64,
    parameter int LANES = 3
) (
    input  logic [WIDTH-1:0]            bitmap,
    output logic [LANES-1:0][WIDTH-1:0] onehot,
    output logic [LANES-1:0]            valid
);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [LANES-1:0][WIDTH-1:0] remain;

    assign remain[0] = bitmap;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            // Two's-complement trick isolates the lowest set bit.
            assign onehot[gi] = remain[gi] & (~remain[gi] + ONE);
            assign valid[gi]  = |remain[gi];
            if (gi < LANES - 1) begin : g_chain
                assign remain[gi+1] = remain[gi] & ~onehot[gi];
            end
        end
    endgenerate
endmodule

// File: rtl/free_list.sv
// Physical-register free list: zero-latency multi-lane allocation from a free bitmap,
// retire-side release, and full bitmap restore on mispredict.
module free_list
    import free_list_pkg::*;
#(
    parameter int N          = DEF_N,
    parameter int PHYS_REGS  = DEF_PHYS_REGS,
    parameter int ARCH_COUNT = DEF_ARCH_COUNT,
    localparam int CW        = $clog2(PHYS_REGS + 1),
    localparam int TW        = $clog2(PHYS_REGS),
    localparam int SW        = $clog2(N + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N-1:0]             alloc_req,
    output logic [N-1:0]             alloc_gnt,
    output logic [N-1:0][TW-1:0]     alloc_tags,
    input  logic [PHYS_REGS-1:0]     free_mask,
    input  logic                     mispredict,
    input  logic [PHYS_REGS-1:0]     restore_mask,
    output logic [CW-1:0]            free_count,
    output logic [SW-1:0]            free_slots
);
    // PR0 is the hard-wired zero register and must never enter the pool.
    localparam logic [PHYS_REGS-1:0] PR0_CLEAR   = {{(PHYS_REGS-1){1'b1}}, 1'b0};
    localparam logic [PHYS_REGS-1:0] RESET_AVAIL =
        {{(PHYS_REGS-ARCH_COUNT){1'b1}}, {ARCH_COUNT{1'b0}}};
    localparam logic [CW-1:0]        RESET_COUNT = CW'(PHYS_REGS - ARCH_COUNT);
    localparam logic [N-1:0]         ONE_N       = {{(N-1){1'b0}}, 1'b1};

    logic [PHYS_REGS-1:0]        avail_reg;
    logic [PHYS_REGS-1:0]        avail_next;
    logic [CW-1:0]               count_reg;
    logic [CW-1:0]               count_next;
    logic [N-1:0][PHYS_REGS-1:0] pick_onehot;
    logic [N-1:0]                pick_valid;
    logic [PHYS_REGS-1:0]        granted_bits;

    nth_free_picker #(
        .WIDTH (PHYS_REGS),
        .LANES (N)
    ) u_picker (
        .bitmap (avail_reg),
        .onehot (pick_onehot),
        .valid  (pick_valid)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            logic [TW-1:0] tag_enc;

            always_comb begin
                tag_enc = '0;
                for (int i = 0; i < PHYS_REGS; i++) begin
                    if (pick_onehot[gi][i]) begin
                        tag_enc = tag_enc | TW'(i);
                    end
                end
            end

            assign alloc_gnt[gi]  = alloc_req[gi] & pick_valid[gi] & ~mispredict & ~reset;
            assign alloc_tags[gi] = alloc_gnt[gi] ? tag_enc : '0;
        end
    endgenerate

    always_comb begin
        granted_bits = '0;
        for (int k = 0; k < N; k++) begin
            if (alloc_gnt[k]) begin
                granted_bits = granted_bits | pick_onehot[k];
            end
        end
    end

    // restore_mask already accounts for this cycle's releases, so free_mask is dropped on a flush.
    always_comb begin
        if (mispredict) begin
            avail_next = restore_mask & PR0_CLEAR;
        end else begin
            avail_next = ((avail_reg & ~granted_bits) | free_mask) & PR0_CLEAR;
        end
    end

    always_comb begin
        count_next = '0;
        for (int i = 0; i < PHYS_REGS; i++) begin
            count_next = count_next + CW'(avail_next[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            avail_reg <= RESET_AVAIL;
            count_reg <= RESET_COUNT;
        end else begin
            avail_reg <= avail_next;
            count_reg <= count_next;
        end
    end

    assign free_count = count_reg;
    assign free_slots = (count_reg > CW'(N)) ? SW'(N) : SW'(count_reg);

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (!mispredict) begin
                assert (((free_mask & PR0_CLEAR) & avail_reg) == '0);
            end
            assert ((alloc_req & (alloc_req + ONE_N)) == '0);
            assert ((alloc_gnt & ~alloc_req) == '0);
        end
    end
`endif
endmodule
